// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: default 640x480@60 mode,
// coordinate width and derived sync window points.
package vga_timing_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_VIS    = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_VIS    = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_SYNC_POL = 1'b0;

    function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = axis_total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = axis_total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Sync windows are half-open: [START, END).
    localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/pix_clk_en_div.sv
// Pixel-rate enable: divides the system clock by CLK_DIV into a registered one-clock strobe.
module pix_clk_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic pix_en_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pix_en_q;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    // The strobe is registered from the terminal count, so the first one lands CLK_DIV clocks after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pix_en_q <= (cnt_q == CNT_LAST);
        end
    end

    assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters advanced on the pixel strobe, with blank, syncs and
// start pulses registered from the next-state counters so they carry no skew.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_en,
    output logic [COORD_W-1:0] hcounter,
    output logic [COORD_W-1:0] vcounter,
    output logic               blank,
    output logic               Hsync,
    output logic               Vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int HT = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int VT = axis_total(V_VIS, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST   = coord_t'(HT - 1);
    localparam coord_t V_LAST   = coord_t'(VT - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VIS);
    localparam coord_t V_VIS_C  = coord_t'(V_VIS);
    localparam coord_t HS_START = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SYNC);

    generate
        if (HT > (1 << COORD_W) || VT > (1 << COORD_W)) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the counter range");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic   pix_strobe;
    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   blank_q, blank_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;

    pix_clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk_i    (clk),
        .rst_i    (rst),
        .pix_en_o (pix_strobe)
    );

    // Decoding from h_d/v_d keeps the registered outputs aligned with the counters they describe.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_strobe) begin
            if (h_q == H_LAST) begin
                h_d          = '0;
                line_start_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        blank_d = (h_d >= H_VIS_C) || (v_d >= V_VIS_C);
        hsync_d = ((h_d >= HS_START) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((v_d >= VS_START) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            blank_q       <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_en      = pix_strobe;
    assign hcounter    = h_q;
    assign vcounter    = v_q;
    assign blank       = blank_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: a closed-form raster model predicts every output from clocks-since-reset,
// for the default mode and two small rasters, under random reset pulses.
module tb_vga_timing_gen;

    localparam int S_HV = 8, S_HFP = 2, S_HS = 2, S_HBP = 2;
    localparam int S_VV = 4, S_VFP = 1, S_VS = 2, S_VBP = 1;
    localparam int S_FRAME = (S_HV + S_HFP + S_HS + S_HBP) * (S_VV + S_VFP + S_VS + S_VBP);

    typedef struct packed {
        logic        pe;
        logic [10:0] h;
        logic [10:0] v;
        logic        bl;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    logic pe0, pe1, pe2, bl0, bl1, bl2, hs0, hs1, hs2, vs0, vs1, vs2;
    logic ls0, ls1, ls2, fs0, fs1, fs2;
    logic [10:0] h0, h1, h2, v0, v1, v2;

    int tests = 0;
    int fails = 0;
    int n0 = 0, n1 = 0, n2 = 0;
    bit st0 = 0, st1 = 0, st2 = 0;
    obs_t q0[$], q1[$], q2[$];

    vga_timing_gen u0 (
        .clk(clk), .rst(rst0), .pix_en(pe0), .hcounter(h0), .vcounter(v0), .blank(bl0),
        .Hsync(hs0), .Vsync(vs0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(1'b0)
    ) u1 (
        .clk(clk), .rst(rst1), .pix_en(pe1), .hcounter(h1), .vcounter(v1), .blank(bl1),
        .Hsync(hs1), .Vsync(vs1), .line_start(ls1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(1'b1)
    ) u2 (
        .clk(clk), .rst(rst2), .pix_en(pe2), .hcounter(h2), .vcounter(v2), .blank(bl2),
        .Hsync(hs2), .Vsync(vs2), .line_start(ls2), .frame_start(fs2)
    );

    // n = clock edges since the last edge that sampled reset; the raster position is the
    // number of strobes already consumed, folded into the frame.
    function automatic obs_t model(input int n, input int d,
                                   input int hv, input int hfp, input int hsw, input int hbp,
                                   input int vv, input int vfp, input int vsw, input int vbp,
                                   input bit pol);
        int   ht = hv + hfp + hsw + hbp;
        int   vt = vv + vfp + vsw + vbp;
        int   adv = (n > 0) ? (n - 1) / d : 0;
        bit   stepped = (n > 1) && (((n - 1) % d) == 0);
        int   p = adv % (ht * vt);
        int   h = p % ht;
        int   v = p / ht;
        obs_t o;
        o.pe = (n > 0) && ((n % d) == 0);
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.bl = (h >= hv) || (v >= vv);
        o.hs = (h >= hv + hfp && h < hv + hfp + hsw) ? pol : !pol;
        o.vs = (v >= vv + vfp && v < vv + vfp + vsw) ? pol : !pol;
        o.ls = stepped && (h == 0);
        o.fs = stepped && (p == 0);
        return o;
    endfunction

    function automatic obs_t modelDef(input int n);
        return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction

    function automatic obs_t modelSmall(input int n, input int d, input bit pol);
        return model(n, d, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, pol);
    endfunction

    task automatic checkOutput(input string nm, input obs_t g, input obs_t e);
        tests++;
        if (g !== e) begin
            fails++;
            if (fails <= 25)
                $display("[TB] FAIL %s: got pe=%b h=%0d v=%0d bl=%b hs=%b vs=%b ls=%b fs=%b, expected pe=%b h=%0d v=%0d bl=%b hs=%b vs=%b ls=%b fs=%b",
                         nm, g.pe, g.h, g.v, g.bl, g.hs, g.vs, g.ls, g.fs,
                         e.pe, e.h, e.v, e.bl, e.hs, e.vs, e.ls, e.fs);
        end
    endtask

    task automatic checkCount(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Expected responses are pushed on every edge once the instance has seen a reset.
    always @(posedge clk) begin
        if (rst0) begin n0 = 0; st0 = 1; end else if (st0) n0++;
        if (rst1) begin n1 = 0; st1 = 1; end else if (st1) n1++;
        if (rst2) begin n2 = 0; st2 = 1; end else if (st2) n2++;
        if (st0) q0.push_back(modelDef(n0));
        if (st1) q1.push_back(modelSmall(n1, 1, 1'b0));
        if (st2) q2.push_back(modelSmall(n2, 3, 1'b1));
    end

    always @(negedge clk) begin
        obs_t g;
        if (q0.size() > 0) begin
            g = '{pe:pe0, h:h0, v:v0, bl:bl0, hs:hs0, vs:vs0, ls:ls0, fs:fs0};
            checkOutput("u0_raster", g, q0.pop_front());
        end
        if (q1.size() > 0) begin
            g = '{pe:pe1, h:h1, v:v1, bl:bl1, hs:hs1, vs:vs1, ls:ls1, fs:fs1};
            checkOutput("u1_raster", g, q1.pop_front());
        end
        if (q2.size() > 0) begin
            g = '{pe:pe2, h:h2, v:v2, bl:bl2, hs:hs2, vs:vs2, ls:ls2, fs:fs2};
            checkOutput("u2_raster", g, q2.pop_front());
        end
    end

    task automatic applyStimulus(input int which, input int cycles);
        case (which)
            0: rst0 = 1'b1;
            1: rst1 = 1'b1;
            default: rst2 = 1'b1;
        endcase
        repeat (cycles) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;
    endtask

    initial begin
        bit   found;
        int   cnt, cnt2;
        int   left0, left1, left2;
        obs_t cur;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;

        // Default mode: one full line starting at a line_start pulse, 2 clocks per pixel.
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (ls0) found = 1;
        end
        checkCount("u0_line_start_seen", int'(found), 1);
        if (found) begin
            cnt = 0;
            cnt2 = 0;
            for (int i = 0; i < 1600; i++) begin
                if (i > 0) @(negedge clk);
                if (!hs0) cnt++;
                if (bl0) cnt2++;
            end
            checkCount("u0_hsync_low_clks", cnt, 192);
            checkCount("u0_blank_clks", cnt2, 320);
            @(negedge clk);
            checkCount("u0_next_line_start", int'(ls0), 1);
        end

        // CLK_DIV=1 small raster: frame_start spacing equals the frame size in clocks.
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (fs1) found = 1;
        end
        cnt = 0;
        if (found) begin
            found = 0;
            for (int i = 0; i < 500 && !found; i++) begin
                @(negedge clk);
                cnt++;
                if (fs1) found = 1;
            end
        end
        checkCount("u1_frame_seen", int'(found), 1);
        checkCount("u1_frame_clks", cnt, S_FRAME);

        // CLK_DIV=3 active-high small raster: Vsync and blank occupancy over one frame.
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (fs2) found = 1;
        end
        checkCount("u2_frame_seen", int'(found), 1);
        cnt = 0;
        cnt2 = 0;
        for (int i = 0; i < S_FRAME * 3; i++) begin
            if (i > 0) @(negedge clk);
            if (vs2) cnt++;
            if (bl2) cnt2++;
        end
        checkCount("u2_vsync_clks", cnt, 2 * 14 * 3);
        checkCount("u2_blank_clks", cnt2, (S_FRAME - S_HV * S_VV) * 3);

        // Reset u1 while it sits inside both sync windows.
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            cur = modelSmall(n1, 1, 1'b0);
            if (cur.h >= 10 && cur.h <= 11 && cur.v >= 5 && cur.v <= 6) found = 1;
        end
        checkCount("u1_sync_window_reached", int'(found), 1);
        applyStimulus(1, 1);
        checkOutput("u1_after_sync_reset",
                    '{pe:pe1, h:h1, v:v1, bl:bl1, hs:hs1, vs:vs1, ls:ls1, fs:fs1},
                    '{pe:1'b0, h:11'd0, v:11'd0, bl:1'b0, hs:1'b1, vs:1'b1, ls:1'b0, fs:1'b0});

        // Random reset pulses of 1-3 clocks on all instances.
        left0 = 0;
        left1 = 0;
        left2 = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (left0 > 0) left0--; else if ($urandom_range(0, 999) == 0) left0 = $urandom_range(1, 3);
            if (left1 > 0) left1--; else if ($urandom_range(0, 149) == 0) left1 = $urandom_range(1, 3);
            if (left2 > 0) left2--; else if ($urandom_range(0, 249) == 0) left2 = $urandom_range(1, 3);
            rst0 = (left0 > 0);
            rst1 = (left1 > 0);
            rst2 = (left2 > 0);
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;
        repeat (400) @(negedge clk);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
